// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - in-order branch resolution queue producing BLT updates and mispredict flushes
module branch_resolve #(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dec_push,
  input  logic [ADDR_WIDTH-1:0] dec_pc,
  input  logic                  dec_pred_taken,
  input  logic [ADDR_WIDTH-1:0] dec_pred_target,
  output logic                  full,
  output logic                  empty,
  input  logic                  ex_resolve,
  input  logic                  ex_taken,
  input  logic [ADDR_WIDTH-1:0] ex_target,
  output logic                  blt_write,
  output logic [ADDR_WIDTH-1:0] blt_write_key,
  output logic [ADDR_WIDTH-1:0] blt_write_val,
  output logic                  blt_hit,
  output logic                  flush,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  underflow,
  output logic [CNT_WIDTH-1:0]  branch_count,
  output logic [CNT_WIDTH-1:0]  mispredict_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage; occupancy is tracked by r_count so the arrays need no reset
  logic [ADDR_WIDTH-1:0] r_pc_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_tg_mem [DEPTH];
  logic [DEPTH-1:0]      r_pt_mem;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [ADDR_WIDTH-1:0] r_key;
  logic [ADDR_WIDTH-1:0] r_val;
  logic [ADDR_WIDTH-1:0] r_redirect;
  logic                  r_write;
  logic                  r_hit;
  logic                  r_flush;
  logic                  r_underflow;
  logic [CNT_WIDTH-1:0]  r_branch_cnt;
  logic [CNT_WIDTH-1:0]  r_mis_cnt;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_mis;
  logic                  w_push;
  logic [ADDR_WIDTH-1:0] w_head_pc;
  logic [ADDR_WIDTH-1:0] w_head_tg;
  logic                  w_head_pt;
  logic [ADDR_WIDTH-1:0] w_redirect;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  assign w_head_pc = r_pc_mem[r_head];
  assign w_head_tg = r_tg_mem[r_head];
  assign w_head_pt = r_pt_mem[r_head];

  // Resolve/mispredict decode; a mispredict kills the wrong-path push in the same cycle
  always_comb begin
    w_pop      = ex_resolve && !w_empty;
    w_mis      = w_pop && ((w_head_pt != ex_taken) ||
                           (w_head_pt && ex_taken && (w_head_tg != ex_target)));
    w_push     = dec_push && (!w_full || w_pop) && !w_mis;
    w_redirect = ex_taken ? ex_target : (w_head_pc + ADDR_WIDTH'(1));
  end

  // Entry write at tail
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_tail] <= dec_pc;
      r_tg_mem[r_tail] <= dec_pred_target;
      r_pt_mem[r_tail] <= dec_pred_taken;
    end
  end

  // Pointer and occupancy update; mispredict collapses the queue to empty at the tail
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_mis) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Registered BLT update, flush pulse, sticky underflow and statistics
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_write      <= 1'b0;
      r_key        <= '0;
      r_val        <= '0;
      r_hit        <= 1'b0;
      r_flush      <= 1'b0;
      r_redirect   <= '0;
      r_underflow  <= 1'b0;
      r_branch_cnt <= '0;
      r_mis_cnt    <= '0;
    end else begin
      r_write <= w_pop;
      r_flush <= w_mis;
      if (w_pop) begin
        r_key        <= w_head_pc;
        r_val        <= ex_target;
        r_hit        <= ex_taken;
        r_branch_cnt <= r_branch_cnt + CNT_WIDTH'(1);
      end
      if (w_mis) begin
        r_redirect <= w_redirect;
        r_mis_cnt  <= r_mis_cnt + CNT_WIDTH'(1);
      end
      if (ex_resolve && w_empty) r_underflow <= 1'b1;
    end
  end

  assign full             = w_full;
  assign empty            = w_empty;
  assign blt_write        = r_write;
  assign blt_write_key    = r_key;
  assign blt_write_val    = r_val;
  assign blt_hit          = r_hit;
  assign flush            = r_flush;
  assign redirect_pc      = r_redirect;
  assign underflow        = r_underflow;
  assign branch_count     = r_branch_cnt;
  assign mispredict_count = r_mis_cnt;

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - scoreboard bench for branch_resolve against a queue-based model
module tb_branch_resolve;

  localparam int AW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          dec_push;
  logic [AW-1:0] dec_pc;
  logic          dec_pred_taken;
  logic [AW-1:0] dec_pred_target;
  logic          full;
  logic          empty;
  logic          ex_resolve;
  logic          ex_taken;
  logic [AW-1:0] ex_target;
  logic          blt_write;
  logic [AW-1:0] blt_write_key;
  logic [AW-1:0] blt_write_val;
  logic          blt_hit;
  logic          flush;
  logic [AW-1:0] redirect_pc;
  logic          underflow;
  logic [CW-1:0] branch_count;
  logic [CW-1:0] mispredict_count;

  branch_resolve #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .dec_push         (dec_push),
    .dec_pc           (dec_pc),
    .dec_pred_taken   (dec_pred_taken),
    .dec_pred_target  (dec_pred_target),
    .full             (full),
    .empty            (empty),
    .ex_resolve       (ex_resolve),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .blt_write        (blt_write),
    .blt_write_key    (blt_write_key),
    .blt_write_val    (blt_write_val),
    .blt_hit          (blt_hit),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .underflow        (underflow),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    bit            pt;
    logic [AW-1:0] tg;
  } ent_t;

  typedef struct {
    int            due;
    logic [AW-1:0] key;
    logic [AW-1:0] val;
    bit            hit;
    bit            fl;
    logic [AW-1:0] rd;
  } exp_t;

  ent_t          m_q[$];
  exp_t          exp_q[$];
  logic [CW-1:0] m_bc;
  logic [CW-1:0] m_mc;
  bit            m_under;
  int            cyc;
  int            checks;
  int            errors;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever an update is due and checks the DUT's pulses
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("blt_write", blt_write, 1);
      chk("blt_write_key", blt_write_key, e.key);
      chk("blt_write_val", blt_write_val, e.val);
      chk("blt_hit", blt_hit, e.hit);
      chk("flush", flush, e.fl);
      if (e.fl) chk("redirect_pc", redirect_pc, e.rd);
    end else if (blt_write || flush) begin
      chk("spurious_pulse", {blt_write, flush}, 0);
    end
  end

  // One cycle: check observable state against the model, drive inputs, advance the model
  task automatic step(input bit rst, input bit push, input logic [AW-1:0] pc, input bit pt,
                      input logic [AW-1:0] ptg, input bit res, input bit tk,
                      input logic [AW-1:0] tgt);
    ent_t h;
    ent_t n;
    exp_t e;
    bit   mis;
    chk("full", full, m_q.size() == DEPTH);
    chk("empty", empty, m_q.size() == 0);
    chk("branch_count", branch_count, m_bc);
    chk("mispredict_count", mispredict_count, m_mc);
    chk("underflow", underflow, m_under);
    reset = rst; dec_push = push; dec_pc = pc; dec_pred_taken = pt; dec_pred_target = ptg;
    ex_resolve = res; ex_taken = tk; ex_target = tgt;
    if (!rst) begin
      m_q.delete();
      m_bc = '0; m_mc = '0; m_under = 0;
    end else begin
      mis = 0;
      if (res && m_q.size() == 0) m_under = 1;
      if (res && m_q.size() > 0) begin
        h     = m_q.pop_front();
        mis   = (h.pt != tk) || (h.pt && tk && h.tg != tgt);
        e.due = cyc + 1; e.key = h.pc; e.val = tgt; e.hit = tk; e.fl = mis;
        e.rd  = tk ? tgt : AW'(h.pc + 1);
        exp_q.push_back(e);
        m_bc++;
        if (mis) begin
          m_mc++;
          m_q.delete();
        end
      end
      if (push && !mis && m_q.size() < DEPTH) begin
        n.pc = pc; n.pt = pt; n.tg = ptg;
        m_q.push_back(n);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Resolve the oldest entry exactly as predicted, optionally pushing alongside
  task automatic good_resolve(input bit push, input logic [AW-1:0] pc);
    step(1, push, pc, pc[0], AW'(pc + 16'h100), 1, m_q[0].pt, m_q[0].tg);
  endtask

  initial begin
    logic [AW-1:0] rpc;
    logic [AW-1:0] rtg;
    bit            rtk;
    checks = 0; errors = 0; cyc = 0;
    m_bc = '0; m_mc = '0; m_under = 0;
    reset = 0; dec_push = 0; dec_pc = '0; dec_pred_taken = 0; dec_pred_target = '0;
    ex_resolve = 0; ex_taken = 0; ex_target = '0;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Correct taken prediction
    step(1, 1, 16'h10, 1, 16'h40, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1, 16'h40);
    idle();
    chk("bc_after_first", branch_count, 1);

    // Not-taken predicted, actually taken; same-cycle push dropped
    step(1, 1, 16'h20, 0, 16'h0, 0, 0, 0);
    step(1, 1, 16'h21, 0, 16'h0, 1, 1, 16'h80);
    idle();
    chk("empty_after_mis", empty, 1);
    chk("mc_after_mis", mispredict_count, 1);

    // Taken predicted, actually not-taken -> redirect to pc+1
    step(1, 1, 16'h30, 1, 16'h50, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 16'h50);
    idle();

    // Fill, overflow push, then push+resolve at full across pointer wrap
    for (int i = 0; i < DEPTH; i++) step(1, 1, AW'(16'h100 + i), i[0], AW'(16'h200 + i), 0, 0, 0);
    chk("full_after_fill", full, 1);
    step(1, 1, 16'h1ff, 1, 16'h2ff, 0, 0, 0);
    for (int i = 0; i < 10; i++) good_resolve(1, AW'(16'h110 + i));
    chk("full_after_stream", full, 1);
    while (m_q.size() > 0) good_resolve(0, 0);
    idle();

    // Resolve while empty
    step(1, 0, 0, 0, 0, 1, 1, 16'h77);
    idle(); idle();
    chk("underflow_sticky", underflow, 1);

    // Reset mid-operation with a resolve pending
    for (int i = 0; i < 3; i++) step(1, 1, AW'(16'h300 + i), 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 16'h99);
    idle();
    chk("empty_after_reset", empty, 1);
    chk("underflow_after_reset", underflow, 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rpc = AW'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        step(0, 0, 0, 0, 0, 0, 0, 0);
      end else if (m_q.size() > 0 && $urandom_range(0, 9) < 6) begin
        step(1, $urandom_range(0, 1), rpc, rpc[3], AW'($urandom), $urandom_range(0, 1),
             m_q[0].pt, m_q[0].tg);
      end else begin
        rtk = $urandom_range(0, 1);
        rtg = (m_q.size() > 0 && $urandom_range(0, 1)) ? m_q[0].tg : AW'($urandom);
        step(1, $urandom_range(0, 3) != 0, rpc, rpc[3], AW'($urandom),
             $urandom_range(0, 2) == 0, rtk, rtg);
      end
    end

    idle(); idle();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
